// File: rtl/complex_ram_2r1w_if.sv
// Request/response bundle for the 2-read/1-write complex-sample RAM.
// master drives requests, slave (the RAM) returns read data and busy.
interface complex_ram_2r1w_if #(
   parameter int A_LEN = 5,
   parameter int W     = 16
);
   logic             we;
   logic [A_LEN-1:0] waddr;
   logic             wbitrev;
   logic [2*W-1:0]   wdata;
   logic             re1;
   logic [A_LEN-1:0] raddr1;
   logic [2*W-1:0]   rdata1;
   logic             re2;
   logic [A_LEN-1:0] raddr2;
   logic [2*W-1:0]   rdata2;
   logic             busy;

   modport master (
      output we, waddr, wbitrev, wdata, re1, raddr1, re2, raddr2,
      input  rdata1, rdata2, busy
   );

   modport slave (
      input  we, waddr, wbitrev, wdata, re1, raddr1, re2, raddr2,
      output rdata1, rdata2, busy
   );
endinterface

// File: rtl/complex_ram_2r1w.sv
// Complex-sample RAM, two registered read ports and one write port with optional
// bit-reversed write addressing; zeroes itself after every reset before serving requests.
module complex_ram_2r1w #(
   parameter int DEPTH = 32,
   parameter int A_LEN = 5,
   parameter int W     = 16
) (
   input logic                clk,
   input logic                rst,
   complex_ram_2r1w_if.slave  bus
);
   localparam logic [A_LEN:0]   DEPTH_L = (A_LEN+1)'(DEPTH);
   localparam logic [A_LEN-1:0] LAST_L  = A_LEN'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   state_e           state_q;
   logic [A_LEN-1:0] cnt_q;
   logic             busy_q;
   logic [2*W-1:0]   rdata1_q, rdata1_d;
   logic [2*W-1:0]   rdata2_q, rdata2_d;
   logic [2*W-1:0]   mem_q [DEPTH];

   logic [A_LEN-1:0] pa;
   logic             wr_ok;
   logic             mem_we;
   logic [A_LEN-1:0] mem_addr;
   logic [2*W-1:0]   mem_wdata;

   always_comb begin
      pa = bus.waddr;
      if (bus.wbitrev) begin
         for (int i = 0; i < A_LEN; i++) begin
            pa[i] = bus.waddr[A_LEN-1-i];
         end
      end
   end

   assign wr_ok = (state_q == ST_READY) && bus.we && ({1'b0, pa} < DEPTH_L);

   // The clear sequence and normal writes share the single memory write port.
   always_comb begin
      mem_we    = !rst && ((state_q == ST_CLEAR) || wr_ok);
      mem_addr  = (state_q == ST_CLEAR) ? cnt_q : pa;
      mem_wdata = (state_q == ST_CLEAR) ? '0 : bus.wdata;
   end

   // NOTE: the storage array has no reset term so it maps onto RAM macros;
   // zeroing is done by the clear sequence instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   // Write-first: a read matching this edge's accepted write returns the new word.
   always_comb begin
      rdata1_d = rdata1_q;
      if (bus.re1) begin
         if (wr_ok && (bus.raddr1 == pa))            rdata1_d = bus.wdata;
         else if ({1'b0, bus.raddr1} < DEPTH_L)      rdata1_d = mem_q[bus.raddr1];
         else                                        rdata1_d = '0;
      end
   end

   always_comb begin
      rdata2_d = rdata2_q;
      if (bus.re2) begin
         if (wr_ok && (bus.raddr2 == pa))            rdata2_d = bus.wdata;
         else if ({1'b0, bus.raddr2} < DEPTH_L)      rdata2_d = mem_q[bus.raddr2];
         else                                        rdata2_d = '0;
      end
   end

   // NOTE: all state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_CLEAR;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_L) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            ST_READY: begin
               rdata1_q <= rdata1_d;
               rdata2_q <= rdata2_d;
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign bus.rdata1 = rdata1_q;
   assign bus.rdata2 = rdata2_q;
   assign bus.busy   = busy_q;
endmodule
